// File: rtl/replica_pkg.sv
// replica_pkg: shared exchange command encoding, city division constants and scheduler states
package replica_pkg;
  localparam int city_div = 8;
  localparam int city_div_log = 3;
  typedef enum logic [1:0] {NOP, PREV, FOLW, SELF} exchange_command_t;
  typedef enum logic [2:0] {IDLE, ISSUE, RUN, DRAIN, HOST} sched_state_t;
endpackage

// File: rtl/exchange_pair_map.sv
// exchange_pair_map: masks swap requests by pairing phase and maps honoured pairs to node commands
module exchange_pair_map import replica_pkg::*; #(
  parameter int replica_num = 32,
  localparam int cw = $clog2(replica_num) + 1
) (
  input  logic odd,
  input  logic [replica_num-1:0] swap,
  output exchange_command_t [replica_num-1:0] command,
  output logic [cw-1:0] pair_cnt
);
  logic [replica_num-1:0] msk, hon, prv;
  always_comb begin
    msk = '0;
    for (int i = 0; i < replica_num - 1; i++) msk[i] = (i[0] == odd);
  end
  assign hon = swap & msk;
  assign prv = hon << 1;
  assign pair_cnt = cw'($countones(hon));
  always_comb begin
    for (int i = 0; i < replica_num; i++) command[i] = hon[i] ? FOLW : prv[i] ? PREV : SELF;
  end
endmodule

// File: rtl/exchange_sched.sv
// exchange_sched: sequences one exchange step (issue, run, drain) and arbitrates host ordering reads.
// Define EXCHANGE_SCHED_STAT_EN to add step_cnt/swap_cnt statistics outputs.
module exchange_sched import replica_pkg::*; #(
  parameter int replica_num = 32,
  parameter int pipe_lat = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic odd,
  input  logic [replica_num-1:0] swap,
  output exchange_command_t [replica_num-1:0] command,
  output logic busy,
  output logic done,
  input  logic ord_req,
  output logic ord_ack,
  input  logic ord_end,
  output logic ordering_read
`ifdef EXCHANGE_SCHED_STAT_EN
  ,
  output logic [31:0] step_cnt,
  output logic [31:0] swap_cnt
`endif
);
  localparam int dw = $clog2(pipe_lat) > 0 ? $clog2(pipe_lat) : 1;
  localparam int cw = $clog2(replica_num) + 1;
  sched_state_t state, state_n;
  logic odd_q;
  logic [replica_num-1:0] swap_q;
  logic [city_div_log-1:0] run_cnt;
  logic [dw-1:0] drain_cnt;
  logic last_run, last_drain;
  exchange_command_t [replica_num-1:0] map_cmd;
`ifdef EXCHANGE_SCHED_STAT_EN
  logic [cw-1:0] pair_cnt;
`endif
  exchange_pair_map #(.replica_num(replica_num)) u_map (
    .odd(odd_q),
    .swap(swap_q),
    .command(map_cmd),
`ifdef EXCHANGE_SCHED_STAT_EN
    .pair_cnt(pair_cnt)
`else
    .pair_cnt()
`endif
  );
  assign last_run = run_cnt == city_div_log'(city_div - 1);
  assign last_drain = drain_cnt == dw'(pipe_lat - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? ISSUE : ord_req ? HOST : IDLE;
      ISSUE:   state_n = RUN;
      RUN:     state_n = last_run ? DRAIN : RUN;
      DRAIN:   state_n = last_drain ? IDLE : DRAIN;
      HOST:    state_n = ord_end ? IDLE : HOST;
      default: state_n = IDLE;
    endcase
    busy = state != IDLE;
    ord_ack = state == HOST;
    ordering_read = state == HOST;
    for (int i = 0; i < replica_num; i++) command[i] = (state == ISSUE) ? map_cmd[i] : NOP;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      odd_q <= 1'b0;
      swap_q <= '0;
      run_cnt <= '0;
      drain_cnt <= '0;
      done <= 1'b0;
`ifdef EXCHANGE_SCHED_STAT_EN
      step_cnt <= '0;
      swap_cnt <= '0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        odd_q <= odd;
        swap_q <= swap;
      end
      run_cnt <= (state == RUN && !last_run) ? run_cnt + 1'b1 : '0;
      drain_cnt <= (state == DRAIN && !last_drain) ? drain_cnt + 1'b1 : '0;
      done <= state == DRAIN && last_drain;
`ifdef EXCHANGE_SCHED_STAT_EN
      if (state == DRAIN && last_drain) begin
        step_cnt <= step_cnt + 32'd1;
        swap_cnt <= swap_cnt + 32'(pair_cnt);
      end
`endif
    end
  end
endmodule

// File: tb/tb_exchange_sched.sv
// tb_exchange_sched: scoreboard bench; stimulus queues expected commands/done/ack, a monitor checks them
module tb_exchange_sched;
  import replica_pkg::*;
  localparam int rn = 4;
  localparam int pl = 3;
  localparam int lat = 2 + city_div + pl;
  typedef enum {E_CMD, E_DONE, E_ACK} ev_t;
  typedef struct {ev_t kind; logic [7:0] val; int cyc;} exp_t;
  logic clk = 0, reset = 0, start = 0, odd = 0, ord_req = 0, ord_end = 0;
  logic [rn-1:0] swap = '0;
  exchange_command_t [rn-1:0] command;
  logic busy, done, ord_ack, ordering_read;
`ifdef EXCHANGE_SCHED_STAT_EN
  logic [31:0] step_cnt, swap_cnt;
`endif
  int errs = 0, checks = 0, cyc = 0;
  exp_t q[$];
  logic ack_d = 0;
  logic [7:0] cv;

  exchange_sched #(.replica_num(rn), .pipe_lat(pl)) dut (
    .clk(clk), .reset(reset), .start(start), .odd(odd), .swap(swap),
    .command(command), .busy(busy), .done(done), .ord_req(ord_req),
    .ord_ack(ord_ack), .ord_end(ord_end), .ordering_read(ordering_read)
`ifdef EXCHANGE_SCHED_STAT_EN
    , .step_cnt(step_cnt), .swap_cnt(swap_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic ev(ev_t k, logic [7:0] v);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL unexpected_event: got kind %0d value %0h at cycle %0d, expected nothing", k, v, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", 32'(k), 32'(e.kind));
      chk("event_value", 32'(v), 32'(e.val));
      chk("event_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    cv = command;
    if (ordering_read) chk("read_exclusive_cmd", 32'(cv), 32'h0);
    if (cv != 8'h0) ev(E_CMD, cv);
    if (done) ev(E_DONE, 8'h0);
    if (ord_ack && !ack_d) ev(E_ACK, 8'h0);
    ack_d = ord_ack;
  end

  task automatic step(logic o, logic [rn-1:0] sw, logic [7:0] exp_cmd, bit hold_req);
    @(negedge clk);
    q.push_back('{E_CMD, exp_cmd, cyc + 1});
    q.push_back('{E_DONE, 8'h0, cyc + lat});
    if (hold_req) q.push_back('{E_ACK, 8'h0, cyc + lat + 1});
    odd = o;
    swap = sw;
    start = 1;
    if (hold_req) ord_req = 1;
    @(negedge clk);
    start = 0;
    odd = ~o;
    swap = ~sw;
  endtask

  task automatic wait_idle(string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) return;
    end
    checks++;
    errs++;
    $display("FAIL %s_timeout: busy=%0d pending=%0d, required idle with none pending", name, busy, q.size());
  endtask

  task automatic wait_q(string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (q.size() == 0) return;
    end
    checks++;
    errs++;
    $display("FAIL %s_timeout: pending=%0d, required 0", name, q.size());
  endtask

  task automatic chk_stat(string name, int s, int w);
`ifdef EXCHANGE_SCHED_STAT_EN
    chk({name, "_step_cnt"}, step_cnt, 32'(s));
    chk({name, "_swap_cnt"}, swap_cnt, 32'(w));
`else
    chk({name, "_busy"}, 32'(busy), 32'h0);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    cv = command;
    chk("rst_command", 32'(cv), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ord_ack", 32'(ord_ack), 32'h0);
    chk("rst_ordering_read", 32'(ordering_read), 32'h0);
    reset = 1;
    step(1'b0, 4'b0001, 8'hF6, 0);
    wait_idle("even_pair");
    chk_stat("even_pair", 1, 1);
    step(1'b1, 4'b1111, 8'hDB, 0);
    wait_idle("odd_all");
    chk_stat("odd_all", 2, 2);
    step(1'b0, 4'b0101, 8'h66, 1);
    wait_q("start_vs_req");
    @(negedge clk);
    chk("host_busy", 32'(busy), 32'h1);
    chk("host_ordering_read", 32'(ordering_read), 32'h1);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (lat + 2) @(negedge clk);
    chk("host_hold_ack", 32'(ord_ack), 32'h1);
    ord_req = 0;
    ord_end = 1;
    @(negedge clk);
    ord_end = 0;
    chk("host_exit_ack", 32'(ord_ack), 32'h0);
    chk("host_exit_busy", 32'(busy), 32'h0);
    step(1'b1, 4'b0110, 8'hDB, 0);
    wait_idle("after_host");
    chk_stat("after_host", 4, 5);
    @(negedge clk);
    q.push_back('{E_CMD, 8'hF6, cyc + 1});
    odd = 0;
    swap = 4'b0001;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    reset = 0;
    #1;
    cv = command;
    chk("abort_command", 32'(cv), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1;
    chk_stat("abort", 0, 0);
    step(1'b0, 4'b0001, 8'hF6, 0);
    wait_idle("after_abort");
    chk_stat("after_abort", 1, 1);
    @(negedge clk);
    q.push_back('{E_CMD, 8'hFF, cyc + 1});
    q.push_back('{E_DONE, 8'h0, cyc + lat});
    odd = 0;
    swap = 4'b1000;
    start = 1;
    repeat (8) @(negedge clk);
    start = 0;
    wait_idle("held_start");
    repeat (lat + 2) @(negedge clk);
    chk_stat("held_start", 2, 1);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
endmodule
